arbiter_2_to_1_3bit: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the 2-to-1 3-bit multiplexer and shares that 3-bit path between two clients. It sequences grants with a request/grant handshake, drives the mux select `S`, and registers the selected 3-bit value with a valid strobe for the downstream datapath stage, such as a register-file write-address port.

---
 rtl/arbiter_pkg.sv | 19 +
 rtl/arb_hold_counter.sv | 33 +++
 rtl/multiplexer_2_to_1_3bit.sv | 13 +
 rtl/arbiter_2_to_1_3bit.sv | 138 +++++++++++++
 tb/tb_arbiter_2_to_1_3bit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and constants for the 2-to-1 round-robin arbiter.
// Latency: none. This file only holds declarations.
// Backpressure: none.
package arbiter_pkg;

  // Default data width of each requester and of the registered output
  localparam int ARB_WIDTH = 3;

  // Width of the hold counter used by the optional grant timeout
  localparam int HOLD_CNT_W = 4;

  // Grant FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/arb_hold_counter.sv
// 4-bit saturating grant-hold counter with clear and an expired flag.
// Latency: count updates one edge after clr/inc; expired is combinational on count.
// Backpressure: none. Only built with ARB_TIMEOUT_EN defined.
`ifdef ARB_TIMEOUT_EN
module arb_hold_counter
  import arbiter_pkg::*;
#(
  parameter logic [HOLD_CNT_W-1:0] LIMIT = 4'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [HOLD_CNT_W-1:0] count,
  output logic                  expired
);

  // Count consecutive cycles of one grant, stopping at LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Count is 0 in the first granted cycle, so LIMIT-1 marks the last allowed cycle
  assign expired = (count >= (LIMIT - 1'b1));

endmodule
`endif

// File: rtl/multiplexer_2_to_1_3bit.sv
// 2-to-1 3-bit combinational mux whose select is owned by the arbiter.
// Latency: combinational, zero cycles.
// Backpressure: none.
module multiplexer_2_to_1_3bit (
  input  logic [2:0] I0,
  input  logic [2:0] I1,
  input  logic       S,
  output logic [2:0] Y
);

  assign Y = S ? I1 : I0;

endmodule

// File: rtl/arbiter_2_to_1_3bit.sv
// Round-robin 2-to-1 arbiter driving the mux select, with registered data/valid output.
// Latency: request to grant 1 cycle, request to Y/VALID 2 cycles; back-to-back handover has no gap.
// Backpressure: requesters hold REQx until done; optional ARB_TIMEOUT_EN preempts a holder after MAX_HOLD cycles under contention.
module arbiter_2_to_1_3bit
  import arbiter_pkg::*;
#(
  parameter int WIDTH    = ARB_WIDTH,
  parameter int MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             S,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] Y,
  output logic             VALID
);

  arb_state_t       state;
  arb_state_t       next_state;
  logic             last;
  logic             hold_expired;
  logic [WIDTH-1:0] mux_out;

  // The hold limit must fit the 4-bit counter and allow at least one cycle
  if ((MAX_HOLD < 1) || (MAX_HOLD > 15)) begin : g_bad_max_hold
    $error("arbiter_2_to_1_3bit: MAX_HOLD out of range 1..15");
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_count;
  logic                  hold_clr;
  logic                  hold_inc;

  // Restart counting on any grant change; count only while someone holds the grant
  assign hold_clr = (next_state != state) || (state == IDLE);
  assign hold_inc = (state != IDLE);

  arb_hold_counter #(
    .LIMIT (HOLD_CNT_W'(MAX_HOLD))
  ) u_hold_counter (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (hold_clr),
    .inc     (hold_inc),
    .count   (hold_count),
    .expired (hold_expired)
  );
`else
  // Without the timeout a holder keeps the grant until it drops its request
  assign hold_expired = 1'b0;
`endif

  // Grant state register and round-robin pointer (last requester granted)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if ((next_state == G0) && (state != G0)) begin
        last <= 1'b0;
      end else if ((next_state == G1) && (state != G1)) begin
        last <= 1'b1;
      end
    end
  end

  // Next grant: holder keeps it unless released or preempted by timeout under contention
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (REQ0 && REQ1) begin
          next_state = last ? G0 : G1;
        end else if (REQ0) begin
          next_state = G0;
        end else if (REQ1) begin
          next_state = G1;
        end
      end
      G0: begin
        if (REQ0 && !(hold_expired && REQ1)) begin
          next_state = G0;
        end else if (REQ1) begin
          next_state = G1;
        end else begin
          next_state = IDLE;
        end
      end
      G1: begin
        if (REQ1 && !(hold_expired && REQ0)) begin
          next_state = G1;
        end else if (REQ0) begin
          next_state = G0;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Grants and select decode straight from the state register
  assign GNT0 = (state == G0);
  assign GNT1 = (state == G1);
  assign S    = (state == G1);

  // Use the shared 3-bit mux when widths match, otherwise an inline select
  if (WIDTH == 3) begin : g_mux3
    multiplexer_2_to_1_3bit u_mux (
      .I0 (I0),
      .I1 (I1),
      .S  (S),
      .Y  (mux_out)
    );
  end else begin : g_mux_inline
    assign mux_out = S ? I1 : I0;
  end

  // Register the selected word; Y holds whenever no grant is active
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Y     <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= GNT0 | GNT1;
      if (GNT0 | GNT1) begin
        Y <= mux_out;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_2_to_1_3bit.sv
// Self-checking bench for arbiter_2_to_1_3bit: directed steps then random traffic.
// Latency: model predicts grants one edge after request and Y/VALID one edge after grant.
// Backpressure: not applicable; requests are driven level-sensitive by the bench.
module tb_arbiter_2_to_1_3bit;

  localparam int W        = 3;
  localparam int MAX_HOLD = 4;

  logic         CLK;
  logic         RST_N;
  logic         REQ0;
  logic         REQ1;
  logic [W-1:0] I0;
  logic [W-1:0] I1;
  logic         S;
  logic         GNT0;
  logic         GNT1;
  logic [W-1:0] Y;
  logic         VALID;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: who holds the grant (-1 none), last winner, cycles held, output pipeline
  int           m_owner;
  int           m_last;
  int           m_held;
  logic         m_valid;
  logic [W-1:0] m_y;

  arbiter_2_to_1_3bit #(
    .WIDTH    (W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .I0    (I0),
    .I1    (I1),
    .S     (S),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .Y     (Y),
    .VALID (VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_held  = 0;
    m_valid = 1'b0;
    m_y     = '0;
  endtask

  // Advance the model by one rising edge using the inputs as sampled there
  task automatic model_edge();
    logic [1:0] rq;
    int nxt;
    if (!RST_N) begin
      model_reset();
      return;
    end
    rq = {REQ1, REQ0};
    if (m_owner >= 0) begin
      m_valid = 1'b1;
      m_y     = (m_owner == 1) ? I1 : I0;
    end else begin
      m_valid = 1'b0;
    end
    if (m_owner >= 0 && rq[m_owner]) begin
      nxt = m_owner;
`ifdef ARB_TIMEOUT_EN
      if (m_held >= MAX_HOLD && rq[1 - m_owner]) nxt = 1 - m_owner;
`endif
    end else if (rq == 2'b11) begin
      nxt = 1 - m_last;
    end else if (rq[0]) begin
      nxt = 0;
    end else if (rq[1]) begin
      nxt = 1;
    end else begin
      nxt = -1;
    end
    if (nxt >= 0 && nxt != m_owner) begin
      m_last = nxt;
      m_held = 1;
    end else if (nxt >= 0) begin
      m_held++;
    end
    m_owner = nxt;
  endtask

  task automatic check_model(input string tag);
    check1({tag, ".gnt0"},  {7'd0, GNT0},  {7'd0, (m_owner == 0)});
    check1({tag, ".gnt1"},  {7'd0, GNT1},  {7'd0, (m_owner == 1)});
    check1({tag, ".s"},     {7'd0, S},     {7'd0, (m_owner == 1)});
    check1({tag, ".valid"}, {7'd0, VALID}, {7'd0, m_valid});
    check1({tag, ".y"},     {5'd0, Y},     {5'd0, m_y});
  endtask

  task automatic check_cleared(input string tag);
    check1({tag, ".gnt0"},  {7'd0, GNT0},  8'd0);
    check1({tag, ".gnt1"},  {7'd0, GNT1},  8'd0);
    check1({tag, ".s"},     {7'd0, S},     8'd0);
    check1({tag, ".valid"}, {7'd0, VALID}, 8'd0);
    check1({tag, ".y"},     {5'd0, Y},     8'd0);
  endtask

  // One clock: edge, model step, then sample on the falling edge
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_model(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    RST_N = 1'b0;
    REQ0  = 1'b1;
    REQ1  = 1'b1;
    I0    = '0;
    I1    = '0;
    model_reset();

    // Reset held with both requests high: everything stays cleared
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check_cleared("reset");
      cycle("reset_model");
    end
    RST_N = 1'b1;
    cycle("release");
    check1("release.first_gnt0", {7'd0, GNT0}, 8'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    run("drain", 3);

    // Single requester for three cycles
    I0   = 3'd1;
    REQ0 = 1'b1;
    run("single", 3);
    REQ0 = 1'b0;
    cycle("single_tail");
    check1("single.y_first", {5'd0, Y}, 8'd1);
    run("single_tail", 3);

    // Make requester 1 the last winner so the next tie favours requester 0
    REQ1 = 1'b1;
    cycle("prime");
    REQ1 = 1'b0;
    run("prime_tail", 3);

    // Two one-cycle ties: first goes to 0 (Y=3), second to 1 (Y=4)
    I0 = 3'd3;
    I1 = 3'd4;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    cycle("tie1");
    check1("tie1.gnt0", {7'd0, GNT0}, 8'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    cycle("tie1_tail");
    check1("tie1.y", {5'd0, Y}, 8'd3);
    run("tie1_tail", 2);
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    cycle("tie2");
    check1("tie2.gnt1", {7'd0, GNT1}, 8'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    cycle("tie2_tail");
    check1("tie2.y", {5'd0, Y}, 8'd4);
    run("tie2_tail", 2);

    // Direct handover G0 -> G1 with continuous VALID
    REQ0 = 1'b1;
    run("hand0", 2);
    REQ0 = 1'b0;
    REQ1 = 1'b1;
    cycle("hand1");
    check1("hand.gnt1", {7'd0, GNT1}, 8'd1);
    check1("hand.y0", {5'd0, Y}, 8'd3);
    cycle("hand1");
    check1("hand.valid", {7'd0, VALID}, 8'd1);
    check1("hand.y1", {5'd0, Y}, 8'd4);
    REQ1 = 1'b0;
    run("hand_tail", 3);

    // Constant contention: holds without timeout, alternates with it
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    run("contend", 14);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    run("contend_tail", 3);

    // Asynchronous reset in the middle of a G1 grant
    I1   = 3'd6;
    REQ1 = 1'b1;
    run("pre_areset", 3);
    @(posedge CLK);
    model_edge();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_cleared("areset");
    @(negedge CLK);
    check_cleared("areset_hold");
    RST_N = 1'b1;
    REQ0  = 1'b1;
    REQ1  = 1'b1;
    cycle("post_areset");
    check1("post_areset.gnt0", {7'd0, GNT0}, 8'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    run("post_areset_tail", 3);

    // Random traffic: sticky requests, fresh data every cycle
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) REQ0 = ~REQ0;
      if ($urandom_range(0, 3) == 0) REQ1 = ~REQ1;
      I0 = W'($urandom_range(0, 7));
      I1 = W'($urandom_range(0, 7));
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
